multicycle_control_unit: RTL

Multicycle MIPS control FSM that replaces the single-cycle opcode/funct decoder in the CPU: it sequences each instruction over 3–5 states and drives the shared-memory datapath (one memory for instructions and data, one ALU, IR/PC registers). It extends the single-cycle instruction set with `bne` and `j`, both parameter-enabled. It adds a memory ready handshake and illegal-instruction trapping. It sits between the instruction register and the datapath muxes/enables.

---
 rtl/multicycle_control_unit_if.sv | 41 ++++
 rtl/multicycle_control_unit.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit_if.sv
// Bundle between the instruction register / memory and the multicycle control FSM.
// The master side is the control unit, the slave side is the datapath.
interface multicycle_control_unit_if #(
  parameter int OP_W    = 6,
  parameter int FUNCT_W = 6
);
  logic [OP_W-1:0]    opcode;
  logic [FUNCT_W-1:0] funct;
  logic               mem_ready;
  logic               mem_req;
  logic               iord;
  logic               memwrite;
  logic               irwrite;
  logic               pcwrite;
  logic               branch;
  logic               branch_ne;
  logic [1:0]         pcsrc;
  logic               alusrca;
  logic [1:0]         alusrcb;
  logic [2:0]         alucontrol;
  logic               regdst;
  logic               memtoreg;
  logic               regwrite;
  logic               illegal;
  logic               instr_done;
  logic [3:0]         state;

  modport master (
    input  opcode, funct, mem_ready,
    output mem_req, iord, memwrite, irwrite, pcwrite, branch, branch_ne, pcsrc,
           alusrca, alusrcb, alucontrol, regdst, memtoreg, regwrite, illegal,
           instr_done, state
  );

  modport slave (
    output opcode, funct, mem_ready,
    input  mem_req, iord, memwrite, irwrite, pcwrite, branch, branch_ne, pcsrc,
           alusrca, alusrcb, alucontrol, regdst, memtoreg, regwrite, illegal,
           instr_done, state
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute over a shared memory
// with a ready handshake, optional bne/j support and illegal-instruction trapping.
module multicycle_control_unit #(
  parameter int OP_W        = 6,
  parameter int FUNCT_W     = 6,
  parameter int ENABLE_JUMP = 1,
  parameter int ENABLE_BNE  = 1
) (
  input logic                       clk,
  input logic                       rst_n,
  multicycle_control_unit_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,  S_ADDIEX = 4'd9,  S_ADDIWB = 4'd10, S_JUMP   = 4'd11,
    S_TRAP   = 4'd12
  } state_t;

  localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OP_J     = OP_W'(6'b000010);
  localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'b000100);
  localparam logic [OP_W-1:0] OP_BNE   = OP_W'(6'b000101);
  localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'b001000);
  localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'b100011);
  localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'b101011);

  localparam logic [FUNCT_W-1:0] F_ADD = FUNCT_W'(6'b100000);
  localparam logic [FUNCT_W-1:0] F_SUB = FUNCT_W'(6'b100010);
  localparam logic [FUNCT_W-1:0] F_AND = FUNCT_W'(6'b100100);
  localparam logic [FUNCT_W-1:0] F_OR  = FUNCT_W'(6'b100101);
  localparam logic [FUNCT_W-1:0] F_SLT = FUNCT_W'(6'b101010);

  // Returns {legal, alucontrol}; unknown funct codes map to AND and are flagged illegal.
  function automatic logic [3:0] funct_dec(input logic [FUNCT_W-1:0] f);
    case (f)
      F_ADD:   return 4'b1_010;
      F_SUB:   return 4'b1_110;
      F_AND:   return 4'b1_000;
      F_OR:    return 4'b1_001;
      F_SLT:   return 4'b1_111;
      default: return 4'b0_000;
    endcase
  endfunction

  state_t     state_q, state_d;
  logic       is_sw_q, is_bne_q;
  logic       funct_ok;
  logic [2:0] alu_fn;

  assign {funct_ok, alu_fn} = funct_dec(bus.funct);
  assign bus.state = state_q;

  // Opcode is only trusted in DECODE, so the facts later states need are captured there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_FETCH;
      is_sw_q  <= 1'b0;
      is_bne_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) begin
        is_sw_q  <= (bus.opcode == OP_SW);
        is_bne_q <= (bus.opcode == OP_BNE);
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    bus.mem_req    = 1'b0;
    bus.iord       = 1'b0;
    bus.memwrite   = 1'b0;
    bus.irwrite    = 1'b0;
    bus.pcwrite    = 1'b0;
    bus.branch     = 1'b0;
    bus.branch_ne  = 1'b0;
    bus.pcsrc      = 2'b00;
    bus.alusrca    = 1'b0;
    bus.alusrcb    = 2'b00;
    bus.alucontrol = 3'b000;
    bus.regdst     = 1'b0;
    bus.memtoreg   = 1'b0;
    bus.regwrite   = 1'b0;
    bus.illegal    = 1'b0;
    bus.instr_done = 1'b0;
    case (state_q)
      S_FETCH: begin
        bus.mem_req    = 1'b1;
        bus.alusrcb    = 2'b01;
        bus.alucontrol = 3'b010;
        bus.irwrite    = bus.mem_ready;
        bus.pcwrite    = bus.mem_ready;
        if (bus.mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        bus.alusrcb    = 2'b11;
        bus.alucontrol = 3'b010;
        if (bus.opcode == OP_LW || bus.opcode == OP_SW)                      state_d = S_MEMADR;
        else if (bus.opcode == OP_RTYPE)                                     state_d = S_EXEC;
        else if (bus.opcode == OP_BEQ || (bus.opcode == OP_BNE && ENABLE_BNE != 0)) state_d = S_BRANCH;
        else if (bus.opcode == OP_ADDI)                                      state_d = S_ADDIEX;
        else if (bus.opcode == OP_J && ENABLE_JUMP != 0)                     state_d = S_JUMP;
        else                                                                 state_d = S_TRAP;
      end
      S_MEMADR, S_ADDIEX: begin
        bus.alusrca    = 1'b1;
        bus.alusrcb    = 2'b10;
        bus.alucontrol = 3'b010;
        if (state_q == S_ADDIEX) state_d = S_ADDIWB;
        else                     state_d = is_sw_q ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        bus.mem_req = 1'b1;
        bus.iord    = 1'b1;
        if (bus.mem_ready) state_d = S_MEMWB;
      end
      S_MEMWR: begin
        bus.mem_req    = 1'b1;
        bus.iord       = 1'b1;
        bus.memwrite   = 1'b1;
        bus.instr_done = bus.mem_ready;
        if (bus.mem_ready) state_d = S_FETCH;
      end
      S_MEMWB: begin
        bus.regwrite   = 1'b1;
        bus.memtoreg   = 1'b1;
        bus.instr_done = 1'b1;
        state_d        = S_FETCH;
      end
      S_EXEC: begin
        bus.alusrca    = 1'b1;
        bus.alucontrol = alu_fn;
        state_d        = funct_ok ? S_ALUWB : S_TRAP;
      end
      S_ALUWB: begin
        bus.regwrite   = 1'b1;
        bus.regdst     = 1'b1;
        bus.instr_done = 1'b1;
        state_d        = S_FETCH;
      end
      S_ADDIWB: begin
        bus.regwrite   = 1'b1;
        bus.instr_done = 1'b1;
        state_d        = S_FETCH;
      end
      S_BRANCH: begin
        bus.alusrca    = 1'b1;
        bus.alucontrol = 3'b110;
        bus.pcsrc      = 2'b01;
        bus.branch     = ~is_bne_q;
        bus.branch_ne  = is_bne_q;
        bus.instr_done = 1'b1;
        state_d        = S_FETCH;
      end
      S_JUMP: begin
        bus.pcwrite    = 1'b1;
        bus.pcsrc      = 2'b10;
        bus.instr_done = 1'b1;
        state_d        = S_FETCH;
      end
      S_TRAP: begin
        bus.illegal    = 1'b1;
        bus.instr_done = 1'b1;
        state_d        = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

endmodule
